pipelined_rca: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. Operands of WIDTH bits are split into STAGES equal chunks; each pipeline stage ripples one chunk through full-adder cells and registers the carry into the next stage. A valid/ready handshake with global stall makes it usable as a datapath element between streaming blocks where a single-cycle WIDTH-bit ripple chain would miss timing.

---
 rtl/pipelined_rca.sv | 140 ++++++++++++++
 tb/tb_pipelined_rca.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca.sv
// pipelined_rca: chunked ripple-carry add/sub, valid/ready, global stall.
// Define PIPELINED_RCA_OVF_EN to add the signed overflow output ovf.
module pipelined_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_RCA_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = WIDTH / STAGES;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;

  logic [WIDTH-1:0] x_a [STAGES];
  logic [WIDTH-1:0] x_b [STAGES];
  logic [WIDTH-1:0] x_s [STAGES];
  logic [STAGES-1:0] x_c, x_v;

  logic advance;

`ifdef PIPELINED_RCA_OVF_EN
  logic ovf_q, ovf_d;
`endif

  assign advance   = !v_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
`ifdef PIPELINED_RCA_OVF_EN
  assign ovf       = ovf_q;
`endif

  // Stage inputs: conditioned operands for stage 0, previous regs after.
  always_comb begin
    x_a    = '{default: '0};
    x_b    = '{default: '0};
    x_s    = '{default: '0};
    x_a[0] = a;
    x_b[0] = b ^ {WIDTH{sub}};
    x_s[0] = '0;
    x_c    = '0;
    x_v    = '0;
    x_c[0] = sub | cin;
    x_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      x_a[k] = a_q[k-1];
      x_b[k] = b_q[k-1];
      x_s[k] = s_q[k-1];
      x_c[k] = c_q[k-1];
      x_v[k] = v_q[k-1];
    end
  end

  always_comb begin
    logic [WIDTH-1:0] sv;
    logic             cv;
`ifdef PIPELINED_RCA_OVF_EN
    logic             cm;
    cm    = 1'b0;
    ovf_d = 1'b0;
`endif
    sv  = '0;
    cv  = 1'b0;
    a_d = '{default: '0};
    b_d = '{default: '0};
    s_d = '{default: '0};
    c_d = '0;
    v_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      sv = x_s[k];
      cv = x_c[k];
      for (int j = 0; j < CW; j++) begin
`ifdef PIPELINED_RCA_OVF_EN
        cm = cv;
`endif
        sv[k*CW+j] = x_a[k][k*CW+j] ^ x_b[k][k*CW+j] ^ cv;
        cv = (x_a[k][k*CW+j] & x_b[k][k*CW+j]) |
             (cv & (x_a[k][k*CW+j] ^ x_b[k][k*CW+j]));
      end
      a_d[k] = x_a[k];
      b_d[k] = x_b[k];
      s_d[k] = sv;
      c_d[k] = cv;
      v_d[k] = x_v[k];
    end
`ifdef PIPELINED_RCA_OVF_EN
    ovf_d = cm ^ cv;
`endif
  end

  // Data loads only with a valid op so the output holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      s_q <= '{default: '0};
`ifdef PIPELINED_RCA_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (advance) begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
`ifdef PIPELINED_RCA_OVF_EN
      if (v_d[STAGES-1]) ovf_q <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: directed table vectors plus stall, bubble, reset runs.
// Define PIPELINED_RCA_OVF_EN to also check the ovf output.
module tb_pipelined_rca;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] s;
    logic         c, o;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c, o;
    int           stamp;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, out_valid, out_ready, cout;
`ifdef PIPELINED_RCA_OVF_EN
  logic         ovf;
`endif

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t e;
  vec_t tbl[13];
  bit   held_v = 0;
  logic [W-1:0] held_s;
  logic held_c;

  pipelined_rca #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum),
`ifdef PIPELINED_RCA_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x,
      input logic [W-1:0] y, input logic ci, input logic sb);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         o;
    be = sb ? ~y : y;
    r  = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, (sb | ci)};
    o  = (x[W-1] == be[W-1]) && (r[W-1] != x[W-1]);
    return {o, r};
  endfunction

  task automatic step(input logic v, input logic [W-1:0] ta,
      input logic [W-1:0] tb, input logic tc, input logic ts,
      input logic rdy, input bit lat, input logic [W-1:0] es,
      input logic ec, input logic eo, output bit acc);
    exp_t x;
    @(negedge clk);
    in_valid  = v;
    a         = ta;
    b         = tb;
    cin       = tc;
    sub       = ts;
    out_ready = rdy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      x.s = es; x.c = ec; x.o = eo;
      x.stamp = cyc; x.lat = lat;
      exp_q.push_back(x);
    end
  endtask

  task automatic idle();
    bit acc;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      idle();
      n++;
    end
    idle();
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Output scoreboard and hold-under-stall check.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (held_v) begin
        chk("hold_sum", {16'h0, sum}, {16'h0, held_s});
        chk("hold_cout", {31'h0, cout}, {31'h0, held_c});
      end
      held_v = out_valid && !out_ready;
      held_s = sum;
      held_c = cout;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {31'h0, out_valid}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", {16'h0, sum}, {16'h0, e.s});
          chk("cout", {31'h0, cout}, {31'h0, e.c});
`ifdef PIPELINED_RCA_OVF_EN
          chk("ovf", {31'h0, ovf}, {31'h0, e.o});
`endif
          if (e.lat) chk("latency", cyc - e.stamp, S);
        end
      end
    end else begin
      held_v = 0;
    end
  end

  initial begin
    logic [W-1:0] ra[8], rb[8];
    logic         rc[8];
    logic [W+1:0] m;
    bit acc;
    int idx, it;

    tbl[0]  = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0};
    tbl[1]  = '{16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0};
    tbl[2]  = '{16'h0007, 16'h0005, 0, 1, 16'h0002, 1, 0};
    tbl[3]  = '{16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0};
    tbl[4]  = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1};
    tbl[5]  = '{16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0};
    tbl[6]  = '{16'h0FFF, 16'h0000, 1, 0, 16'h1000, 0, 0};
    tbl[7]  = '{16'hABCD, 16'h1111, 0, 0, 16'hBCDE, 0, 0};
    tbl[8]  = '{16'h0000, 16'h0001, 0, 1, 16'hFFFF, 0, 0};
    tbl[9]  = '{16'h1234, 16'h1234, 0, 1, 16'h0000, 1, 0};
    tbl[10] = '{16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0};
    tbl[11] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
    tbl[12] = '{16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1};

    for (int i = 0; i < 8; i++) begin
      ra[i] = 16'($urandom());
      rb[i] = 16'($urandom());
      rc[i] = 1'($urandom());
    end

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_sum", {16'h0, sum}, 0);
    chk("rst_cout", {31'h0, cout}, 0);
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Carry across every stage boundary, single op with latency check.
    step(1, tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].sub, 1, 1,
         tbl[0].s, tbl[0].c, tbl[0].o, acc);
    drain();

    // Table vectors back to back.
    for (int i = 1; i < 13; i++) begin
      step(1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1, 1,
           tbl[i].s, tbl[i].c, tbl[i].o, acc);
      chk("tbl_accept", {31'h0, acc}, 1);
    end
    drain();

    // Stream of 8 with a 3-cycle downstream stall mid-stream.
    idx = 0;
    it = 0;
    while (idx < 8 && it < 40) begin
      m = model(ra[idx], rb[idx], rc[idx], 1'b0);
      step(1, ra[idx], rb[idx], rc[idx], 0, !(it >= 6 && it <= 8), 0,
           m[W-1:0], m[W], m[W+1], acc);
      if (it >= 6 && it <= 8)
        chk("stall_in_ready", {31'h0, in_ready}, 0);
      if (acc) idx++;
      it++;
    end
    chk("stall_all_sent", idx, 8);
    drain();

    // Bubbles: valid pattern 1,0,1,0 reappears 4 cycles later.
    for (int i = 0; i < 8; i++) begin
      step((i < 4) && (i % 2 == 0), tbl[3 + i].a, tbl[3 + i].b,
           tbl[3 + i].cin, tbl[3 + i].sub, 1, 1,
           tbl[3 + i].s, tbl[3 + i].c, tbl[3 + i].o, acc);
      if (i >= 4)
        chk("bubble_ov", {31'h0, out_valid}, {31'h0, (i % 2 == 0)});
    end
    drain();

    // Asynchronous reset with operations in flight.
    for (int i = 5; i < 10; i++)
      step(1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1, 0,
           tbl[i].s, tbl[i].c, tbl[i].o, acc);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("pre_rst_ov", {31'h0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'h0, out_valid}, 0);
    chk("arst_sum", {16'h0, sum}, 0);
    chk("arst_cout", {31'h0, cout}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("post_rst_ov", {31'h0, out_valid}, 0);
    end
    step(1, tbl[12].a, tbl[12].b, tbl[12].cin, tbl[12].sub, 1, 1,
         tbl[12].s, tbl[12].c, tbl[12].o, acc);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
